// File: rtl/mccpu_ctrl.sv
// Multi-cycle control FSM for the CPU datapath: FETCH/DECODE/EXEC/MEM/WB sequencing,
// combinational control bundle per state, retired-instruction counter.
module mccpu_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             EXTOp,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR  = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                         ALU_LUI = 4'd8;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;

  logic [3:0] w_alu;
  logic       w_sa, w_sb, w_ext;
  logic       w_legal, w_jmp, w_jal, w_jr, w_br, w_bne, w_lw, w_sw, w_itype;

  // Instruction decode; Op/Funct are held stable in IR from DECODE onward.
  always_comb begin
    w_alu   = ALU_NOP;
    w_sa    = 1'b0;
    w_sb    = 1'b0;
    w_ext   = 1'b0;
    w_legal = 1'b1;
    w_jmp   = 1'b0;
    w_jal   = 1'b0;
    w_jr    = 1'b0;
    w_br    = 1'b0;
    w_bne   = 1'b0;
    w_lw    = 1'b0;
    w_sw    = 1'b0;
    w_itype = 1'b0;
    case (Op)
      6'b000000: begin
        case (Funct)
          6'b100000: w_alu = ALU_ADD;
          6'b100010: w_alu = ALU_SUB;
          6'b100100: w_alu = ALU_AND;
          6'b100101: w_alu = ALU_OR;
          6'b101010: w_alu = ALU_SLT;
          6'b000000: begin w_alu = ALU_SLL; w_sa = 1'b1; end
          6'b000010: begin w_alu = ALU_SRL; w_sa = 1'b1; end
          6'b001000: w_jr = 1'b1;
          default:   w_legal = 1'b0;
        endcase
      end
      6'b001000: begin w_alu = ALU_ADD; w_sb = 1'b1; w_ext = 1'b1; w_itype = 1'b1; end
      6'b001101: begin w_alu = ALU_OR;  w_sb = 1'b1; w_itype = 1'b1; end
      6'b001111: begin w_alu = ALU_LUI; w_sb = 1'b1; w_itype = 1'b1; end
      6'b100011: begin w_alu = ALU_ADD; w_sb = 1'b1; w_ext = 1'b1; w_lw = 1'b1; end
      6'b101011: begin w_alu = ALU_ADD; w_sb = 1'b1; w_ext = 1'b1; w_sw = 1'b1; end
      // Branch offsets are always sign-extended for the NPC target.
      6'b000100: begin w_alu = ALU_SUB; w_ext = 1'b1; w_br = 1'b1; end
      6'b000101: begin w_alu = ALU_SUB; w_ext = 1'b1; w_br = 1'b1; w_bne = 1'b1; end
      6'b000010: w_jmp = 1'b1;
      6'b000011: begin w_jmp = 1'b1; w_jal = 1'b1; end
      default:   w_legal = 1'b0;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    EXTOp    = 1'b0;
    ALUOp    = ALU_NOP;
    NPCOp    = 2'd0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 1'b0;
    GPRSel   = 2'd0;
    WDSel    = 2'd0;
    w_next   = r_state;
    case (r_state)
      S_FETCH: begin
        IRWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal) begin
          illegal = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_FETCH;
        end else if (w_jmp) begin
          PCWrite = 1'b1;
          NPCOp   = 2'd2;
          if (w_jal) begin
            RegWrite = 1'b1;
            GPRSel   = 2'd2;
            WDSel    = 2'd2;
          end
          w_next = S_FETCH;
        end else if (w_jr) begin
          PCWrite = 1'b1;
          NPCOp   = 2'd3;
          w_next  = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUOp   = w_alu;
        ALUSrcA = w_sa;
        ALUSrcB = w_sb;
        EXTOp   = w_ext;
        if (w_br) begin
          PCWrite = 1'b1;
          NPCOp   = (Zero ^ w_bne) ? 2'd1 : 2'd0;
          w_next  = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        // ALU controls held so the memory address stays stable across stalls.
        ALUOp   = w_alu;
        ALUSrcA = w_sa;
        ALUSrcB = w_sb;
        EXTOp   = w_ext;
        if (w_sw) begin
          MemWrite = 1'b1;
          if (mem_ready) begin
            PCWrite = 1'b1;
            w_next  = S_FETCH;
          end
        end else if (mem_ready) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        ALUOp    = w_alu;
        ALUSrcA  = w_sa;
        ALUSrcB  = w_sb;
        EXTOp    = w_ext;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (w_lw) begin
          GPRSel = 2'd1;
          WDSel  = 2'd1;
        end else if (w_itype) begin
          GPRSel = 2'd1;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (PCWrite) r_instret <= r_instret + 1'b1;
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed bench for mccpu_ctrl: per-cycle check of the control bundle and instret.
module tb_mccpu_ctrl;
  logic        clk = 1'b0;
  logic        rst, Zero, mem_ready;
  logic [5:0]  Op, Funct;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrcA, ALUSrcB, illegal;
  logic [3:0]  ALUOp;
  logic [1:0]  NPCOp, GPRSel, WDSel;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [20:0] obs;
  int n_tests = 0;
  int n_fail  = 0;

  mccpu_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {state, PCWrite, IRWrite, RegWrite, MemWrite, illegal, ALUOp, NPCOp, ALUSrcA, ALUSrcB, EXTOp, GPRSel, WDSel}
  assign obs = {state, PCWrite, IRWrite, RegWrite, MemWrite, illegal, ALUOp, NPCOp,
                ALUSrcA, ALUSrcB, EXTOp, GPRSel, WDSel};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check one cycle's outputs (stb = pcw,irw,rw,mw,ill; ab = srcA,srcB), then advance a clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [4:0] stb,
                     input logic [3:0] alu, input logic [1:0] npc, input logic [1:0] ab,
                     input logic ext, input logic [1:0] gs, input logic [1:0] wd);
    logic [20:0] e;
    #1;
    e = {st, stb, alu, npc, ab, ext, gs, wd};
    check_eq(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Zero = 1'b0; mem_ready = 1'b1; Op = 6'd0; Funct = 6'h20;
    @(posedge clk); #1;
    // Reset held in FETCH with mem_ready=1: IRWrite must stay low.
    cyc("rst_hold", 3'd0, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    check_eq("rst_instret", instret, 32'd0);
    rst = 1'b0;

    // add $3,$1,$2
    Op = 6'h00; Funct = 6'h20;
    cyc("add_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("add_d", 3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("add_e", 3'd2, 5'b00000, 4'd1, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("add_w", 3'd4, 5'b10100, 4'd1, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    check_eq("add_instret", instret, 32'd1);

    // lw with 2 fetch stalls and 3 memory stalls: 10 cycles
    Op = 6'h23; Funct = 6'h00; mem_ready = 1'b0;
    cyc("lw_f0", 3'd0, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("lw_f1", 3'd0, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    mem_ready = 1'b1;
    cyc("lw_f2", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("lw_d",  3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("lw_e",  3'd2, 5'b00000, 4'd1, 2'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("lw_mstall", 3'd3, 5'b00000, 4'd1, 2'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    mem_ready = 1'b1;
    cyc("lw_mrdy", 3'd3, 5'b00000, 4'd1, 2'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    cyc("lw_w",    3'd4, 5'b10100, 4'd1, 2'd0, 2'b01, 1'b1, 2'd1, 2'd1);
    check_eq("lw_instret", instret, 32'd2);

    // beq taken then not taken
    Op = 6'h04; Zero = 1'b1;
    cyc("beq1_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("beq1_d", 3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("beq1_e", 3'd2, 5'b10000, 4'd2, 2'd1, 2'b00, 1'b1, 2'd0, 2'd0);
    Zero = 1'b0;
    cyc("beq0_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("beq0_d", 3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("beq0_e", 3'd2, 5'b10000, 4'd2, 2'd0, 2'b00, 1'b1, 2'd0, 2'd0);
    check_eq("beq_instret", instret, 32'd4);

    // jal, then jr $31
    Op = 6'h03;
    cyc("jal_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("jal_d", 3'd1, 5'b10100, 4'd0, 2'd2, 2'b00, 1'b0, 2'd2, 2'd2);
    Op = 6'h00; Funct = 6'h08;
    cyc("jr_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("jr_d", 3'd1, 5'b10000, 4'd0, 2'd3, 2'b00, 1'b0, 2'd0, 2'd0);
    check_eq("jump_instret", instret, 32'd6);

    // Unsupported opcode executes as a NOP
    Op = 6'h3f;
    cyc("ill_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("ill_d", 3'd1, 5'b10001, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    check_eq("ill_instret", instret, 32'd7);

    // sw with 2 memory stalls
    Op = 6'h2b;
    cyc("sw_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("sw_d", 3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("sw_e", 3'd2, 5'b00000, 4'd1, 2'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      cyc("sw_mstall", 3'd3, 5'b00010, 4'd1, 2'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    mem_ready = 1'b1;
    cyc("sw_mrdy", 3'd3, 5'b10010, 4'd1, 2'd0, 2'b01, 1'b1, 2'd0, 2'd0);
    check_eq("sw_instret", instret, 32'd8);
    check_eq("sw_state", 32'(state), 32'd0);

    // ori: zero-extended immediate, writes rt
    Op = 6'h0d;
    cyc("ori_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("ori_d", 3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("ori_e", 3'd2, 5'b00000, 4'd4, 2'd0, 2'b01, 1'b0, 2'd0, 2'd0);
    cyc("ori_w", 3'd4, 5'b10100, 4'd4, 2'd0, 2'b01, 1'b0, 2'd1, 2'd0);

    // sll: shamt on A, RD2 on B
    Op = 6'h00; Funct = 6'h00;
    cyc("sll_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("sll_d", 3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("sll_e", 3'd2, 5'b00000, 4'd6, 2'd0, 2'b10, 1'b0, 2'd0, 2'd0);
    cyc("sll_w", 3'd4, 5'b10100, 4'd6, 2'd0, 2'b10, 1'b0, 2'd0, 2'd0);
    check_eq("alu_instret", instret, 32'd10);

    // Reset asserted in EXEC of a taken beq: PCWrite suppressed, instruction abandoned
    Op = 6'h04; Zero = 1'b1;
    cyc("rbeq_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    cyc("rbeq_d", 3'd1, 5'b00000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);
    rst = 1'b1;
    cyc("rbeq_e_rst", 3'd2, 5'b00000, 4'd2, 2'd1, 2'b00, 1'b1, 2'd0, 2'd0);
    rst = 1'b0;
    check_eq("rst_mid_instret", instret, 32'd0);
    cyc("rst_mid_f", 3'd0, 5'b01000, 4'd0, 2'd0, 2'b00, 1'b0, 2'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mccpu_ctrl.md
Name: mccpu_ctrl

Overview:
- Multi-cycle control FSM that sequences the CPU datapath (PC, IR, RF, EXT, ALU, NPC, data memory) over FETCH/DECODE/EXEC/MEM/WB. It replaces the single-cycle combinational decoder.
- Emits the same datapath control bundle, plus PCWrite/IRWrite strobes, a memory-ready handshake and a retired-instruction counter.
- Sits between the instruction register, the shared memory port and the datapath muxes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  6  opcode from IR[31:26]
- Funct  in  6  function field from IR[5:0]
- Zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory port completed the current fetch or data access this cycle
- PCWrite  out  1  load PC with NPC
- IRWrite  out  1  load IR from memory read data
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  data-memory write request
- EXTOp  out  1  1 = sign-extend, 0 = zero-extend
- ALUOp  out  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLL, 7 SRL, 8 LUI
- NPCOp  out  2  0 PC+4, 1 branch, 2 jump, 3 jr (RD1)
- ALUSrcA  out  1  1 = shamt, 0 = RD1
- ALUSrcB  out  1  1 = Imm32, 0 = RD2
- GPRSel  out  2  write address: 0 rd, 1 rt, 2 r31
- WDSel  out  2  write data: 0 ALU, 1 memory, 2 PC+4
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB (debug)
- instret  out  CNT_W  retired-instruction count
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported encoding

Behaviour:
- Reset: on any rising edge with rst=1, state becomes FETCH and instret becomes 0. While rst=1, every strobe (PCWrite, IRWrite, RegWrite, MemWrite, illegal) is forced to 0. Reset mid-instruction abandons the instruction with no further writes.
- Outputs are combinational from state, Op, Funct, Zero and mem_ready. Unlisted outputs are 0.
- FETCH: IRWrite=mem_ready. Go to DECODE when mem_ready=1, else stay in FETCH.
- DECODE (Op/Funct now valid):
  - j: PCWrite=1, NPCOp=2, then FETCH.
  - jal: additionally RegWrite=1, GPRSel=2, WDSel=2.
  - jr (R-type, funct 001000): PCWrite=1, NPCOp=3, then FETCH.
  - Unsupported encoding: illegal=1, PCWrite=1, NPCOp=0 (executes as NOP), then FETCH.
  - All others: go to EXEC.
- EXEC: drive ALUOp, ALUSrcA, ALUSrcB and EXTOp per decode.
  - beq/bne: ALUOp=SUB, PCWrite=1, NPCOp=1 if (beq & Zero) | (bne & ~Zero), else 0; then FETCH.
  - lw/sw: ADD with sign-extended immediate, then MEM.
  - ALU ops: go to WB.
- MEM: keep the EXEC ALU controls so the address stays stable.
  - sw: MemWrite=1 until mem_ready. On mem_ready: PCWrite=1, NPCOp=0, then FETCH.
  - lw: wait for mem_ready, then WB.
- WB: keep the ALU controls; RegWrite=1, PCWrite=1, NPCOp=0, then FETCH.
  - lw: GPRSel=1, WDSel=1.
  - I-type ALU: GPRSel=1, WDSel=0.
  - R-type: GPRSel=0, WDSel=0.
- Decode table:
  - R-type (Op 000000), funct: add 100000 ADD, sub 100010 SUB, and 100100 AND, or 100101 OR, slt 101010 SLT.
  - sll 000000 and srl 000010 set ALUSrcA=1 with B=RD2.
  - addi 001000: ADD, sign-extend. ori 001101: OR, zero-extend. lui 001111: LUI, zero-extend.
  - lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- instret increments by 1 (wrapping modulo 2^CNT_W) on every cycle with PCWrite=1, including illegal NOPs.
- Cycle counts with mem_ready held at 1: j/jal/jr 2, illegal 2, beq/bne 3, R/I ALU 4, sw 4, lw 5. Each mem_ready=0 cycle in FETCH or MEM adds one cycle.
- Exactly one PCWrite pulse per instruction. No RegWrite and MemWrite in the same cycle.

Test Plan:
- Reset: rst=1 mid-EXEC for one cycle -> next cycle state=0, instret=0; no RegWrite/MemWrite/PCWrite while rst=1.
- add $3,$1,$2 (00221820) with mem_ready=1 -> states 0,1,2,4,0; ALUOp=1; WB asserts RegWrite, GPRSel=0, WDSel=0, PCWrite, NPCOp=0; instret 0->1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEM -> 10 cycles total; IRWrite only on the fetch ready cycle; WB RegWrite with WDSel=1, GPRSel=1.
- beq with Zero=1 then Zero=0 -> EXEC PCWrite with NPCOp=1 then 0; 3 cycles each; RegWrite never asserted.
- jal (0C000010) -> DECODE asserts RegWrite, GPRSel=2, WDSel=2, NPCOp=2, PCWrite; 2 cycles. jr $31 (03E00008) -> NPCOp=3.
- Op=111111 -> illegal pulse in DECODE, PCWrite with NPCOp=0, instret+1. sw -> MemWrite held through mem_ready stall, PCWrite only on the ready cycle.
